// File: rtl/sauria_pkg.sv
// Shared SRAM C geometry, arbiter state encoding and response tag type.
// Used by sramc_arbiter (optional SRAMC_ARB_STATS_EN statistics).
package sauria_pkg;

    localparam int ADRC_W         = 11;
    localparam int SRAMC_W        = 128;
    localparam int SRAMC_N        = 4;
    localparam int OC_W           = SRAMC_W / SRAMC_N;
    localparam int STARVE_LIM_DEF = 8;

    typedef enum logic {
        CORE_PRIO = 1'b0,
        DMA_PRIO  = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic core;
        logic dma;
    } rd_tag_t;

endpackage

// File: rtl/sramc_arbiter_if.sv
// Request, response, SRAM and control bundle of the SRAM C arbiter.
// Signal prefixes are relative to the arbiter (slave modport).
interface sramc_arbiter_if
    import sauria_pkg::*;
#(
    parameter int ADR_W  = ADRC_W,
    parameter int DATA_W = SRAMC_W,
    parameter int LANES  = SRAMC_N
) ();

    logic              i_core_req;
    logic              i_core_wr;
    logic [ADR_W-1:0]  i_core_adr;
    logic [DATA_W-1:0] i_core_wdata;
    logic [LANES-1:0]  i_core_wmask;
    logic              o_core_gnt;

    logic              i_dma_req;
    logic              i_dma_wr;
    logic [ADR_W-1:0]  i_dma_adr;
    logic [DATA_W-1:0] i_dma_wdata;
    logic [LANES-1:0]  i_dma_wmask;
    logic              o_dma_gnt;

    logic              o_core_rvalid;
    logic              o_dma_rvalid;
    logic [DATA_W-1:0] o_rdata;

    logic              o_sram_cen;
    logic              o_sram_wen;
    logic [ADR_W-1:0]  o_sram_adr;
    logic [DATA_W-1:0] o_sram_wdata;
    logic [DATA_W-1:0] o_sram_wmask;
    logic [DATA_W-1:0] i_sram_rdata;

    logic              i_stall;
    logic              o_busy;

    modport slave (
        input  i_core_req, i_core_wr, i_core_adr, i_core_wdata, i_core_wmask,
        output o_core_gnt,
        input  i_dma_req, i_dma_wr, i_dma_adr, i_dma_wdata, i_dma_wmask,
        output o_dma_gnt,
        output o_core_rvalid, o_dma_rvalid, o_rdata,
        output o_sram_cen, o_sram_wen, o_sram_adr, o_sram_wdata, o_sram_wmask,
        input  i_sram_rdata,
        input  i_stall,
        output o_busy
    );

    modport master (
        output i_core_req, i_core_wr, i_core_adr, i_core_wdata, i_core_wmask,
        input  o_core_gnt,
        output i_dma_req, i_dma_wr, i_dma_adr, i_dma_wdata, i_dma_wmask,
        input  o_dma_gnt,
        input  o_core_rvalid, o_dma_rvalid, o_rdata,
        input  o_sram_cen, o_sram_wen, o_sram_adr, o_sram_wdata, o_sram_wmask,
        output i_sram_rdata,
        output i_stall,
        input  o_busy
    );

endinterface

// File: rtl/sramc_rsp_pipe.sv
// Two-stage read response pipe: grant tag, then registered SRAM data.
// Responses are never back-pressured, so the pipe always advances.
module sramc_rsp_pipe
    import sauria_pkg::*;
#(
    parameter int DATA_W = SRAMC_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_rd_core,
    input  logic              i_rd_dma,
    input  logic [DATA_W-1:0] i_sram_rdata,
    output logic              o_core_rvalid,
    output logic              o_dma_rvalid,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_busy
);

    rd_tag_t           r_tag1;
    rd_tag_t           r_tag2;
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_tag1  <= '0;
            r_tag2  <= '0;
            r_rdata <= '0;
        end else begin
            r_tag1 <= rd_tag_t'{core: i_rd_core, dma: i_rd_dma};
            r_tag2 <= r_tag1;
            if (r_tag1.core | r_tag1.dma) begin
                r_rdata <= i_sram_rdata;
            end
        end
    end

    assign o_core_rvalid = r_tag2.core;
    assign o_dma_rvalid  = r_tag2.dma;
    assign o_rdata       = r_rdata;
    assign o_busy        = r_tag1.core | r_tag1.dma | r_tag2.core | r_tag2.dma;

endmodule

// File: rtl/sramc_arbiter.sv
// Core/DMA arbiter for SRAM C with starvation guard and 2-cycle read path.
// Define SRAMC_ARB_STATS_EN to add conflict / forced-DMA statistics.
module sramc_arbiter
    import sauria_pkg::*;
#(
    parameter int ADR_W      = ADRC_W,
    parameter int DATA_W     = SRAMC_W,
    parameter int LANES      = SRAMC_N,
    parameter int STARVE_LIM = STARVE_LIM_DEF
) (
    input  logic        i_clk,
    input  logic        i_rst,
`ifdef SRAMC_ARB_STATS_EN
    input  logic        i_stats_clr,
    output logic [31:0] o_conflicts,
    output logic [31:0] o_dma_forced,
`endif
    sramc_arbiter_if.slave bus
);

    localparam int LANE_W = DATA_W / LANES;

    arb_state_e        r_state;
    arb_state_e        w_state_nxt;
    logic [7:0]        r_starve;
    logic [7:0]        w_starve_nxt;
    logic              w_both;
    logic              w_core_gnt;
    logic              w_dma_gnt;
    logic              w_wr_sel;
    logic [ADR_W-1:0]  w_adr_sel;
    logic [DATA_W-1:0] w_wdata_sel;
    logic [LANES-1:0]  w_mask_sel;
    logic [DATA_W-1:0] w_wmask_exp;

    assign w_both = bus.i_core_req & bus.i_dma_req;

    always_comb begin
        w_core_gnt = 1'b0;
        w_dma_gnt  = 1'b0;
        if (!bus.i_stall) begin
            if (w_both) begin
                w_dma_gnt  = (r_state == DMA_PRIO);
                w_core_gnt = (r_state == CORE_PRIO);
            end else begin
                w_core_gnt = bus.i_core_req;
                w_dma_gnt  = bus.i_dma_req;
            end
        end
    end

    // Unstalled, a waiting DMA in CORE_PRIO can only lose to a core grant.
    always_comb begin
        w_state_nxt  = r_state;
        w_starve_nxt = r_starve;
        if (!bus.i_stall) begin
            unique case (r_state)
                CORE_PRIO: begin
                    if (w_core_gnt && bus.i_dma_req) begin
                        if (int'(r_starve) + 1 >= STARVE_LIM) begin
                            w_starve_nxt = '0;
                            w_state_nxt  = DMA_PRIO;
                        end else begin
                            w_starve_nxt = r_starve + 8'd1;
                        end
                    end else begin
                        w_starve_nxt = '0;
                    end
                end
                DMA_PRIO: begin
                    w_starve_nxt = '0;
                    if (w_dma_gnt || !bus.i_dma_req) begin
                        w_state_nxt = CORE_PRIO;
                    end
                end
                default: begin
                    w_state_nxt  = CORE_PRIO;
                    w_starve_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= CORE_PRIO;
            r_starve <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_starve <= w_starve_nxt;
        end
    end

    always_comb begin
        if (w_dma_gnt) begin
            w_wr_sel    = bus.i_dma_wr;
            w_adr_sel   = bus.i_dma_adr;
            w_wdata_sel = bus.i_dma_wdata;
            w_mask_sel  = bus.i_dma_wmask;
        end else begin
            w_wr_sel    = bus.i_core_wr;
            w_adr_sel   = bus.i_core_adr;
            w_wdata_sel = bus.i_core_wdata;
            w_mask_sel  = bus.i_core_wmask;
        end
    end

    always_comb begin
        w_wmask_exp = '0;
        for (int l = 0; l < LANES; l++) begin
            w_wmask_exp[l*LANE_W +: LANE_W] = {LANE_W{w_mask_sel[l]}};
        end
    end

    assign bus.o_core_gnt   = w_core_gnt;
    assign bus.o_dma_gnt    = w_dma_gnt;
    assign bus.o_sram_cen   = w_core_gnt | w_dma_gnt;
    assign bus.o_sram_wen   = (w_core_gnt | w_dma_gnt) & w_wr_sel;
    assign bus.o_sram_adr   = w_adr_sel;
    assign bus.o_sram_wdata = w_wdata_sel;
    assign bus.o_sram_wmask = w_wmask_exp;

    sramc_rsp_pipe #(
        .DATA_W (DATA_W)
    ) u_rsp_pipe (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_rd_core     (w_core_gnt & ~bus.i_core_wr),
        .i_rd_dma      (w_dma_gnt & ~bus.i_dma_wr),
        .i_sram_rdata  (bus.i_sram_rdata),
        .o_core_rvalid (bus.o_core_rvalid),
        .o_dma_rvalid  (bus.o_dma_rvalid),
        .o_rdata       (bus.o_rdata),
        .o_busy        (bus.o_busy)
    );

`ifdef SRAMC_ARB_STATS_EN
    logic [31:0] r_conflicts;
    logic [31:0] r_dma_forced;

    // A forced grant is a DMA grant that beat a requesting core.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_conflicts  <= '0;
            r_dma_forced <= '0;
        end else if (i_stats_clr) begin
            r_conflicts  <= '0;
            r_dma_forced <= '0;
        end else begin
            if (w_both && (r_conflicts != '1)) begin
                r_conflicts <= r_conflicts + 32'd1;
            end
            if (w_dma_gnt && bus.i_core_req && (r_dma_forced != '1)) begin
                r_dma_forced <= r_dma_forced + 32'd1;
            end
        end
    end

    assign o_conflicts  = r_conflicts;
    assign o_dma_forced = r_dma_forced;
`endif

endmodule

// File: tb/tb_sramc_arbiter.sv
// Directed + random bench for sramc_arbiter against a transaction-level model.
// Build with SRAMC_ARB_STATS_EN to also check the statistics counters.
module tb_sramc_arbiter;
    import sauria_pkg::*;

    localparam int AW  = ADRC_W;
    localparam int DW  = SRAMC_W;
    localparam int LN  = SRAMC_N;
    localparam int LW  = DW / LN;
    localparam int LIM = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sramc_arbiter_if #(.ADR_W(AW), .DATA_W(DW), .LANES(LN)) bus ();

`ifdef SRAMC_ARB_STATS_EN
    logic        stats_clr = 1'b0;
    logic [31:0] conflicts;
    logic [31:0] dma_forced;
    int          m_conf = 0;
    int          m_forced = 0;
`endif

    sramc_arbiter #(
        .ADR_W      (AW),
        .DATA_W     (DW),
        .LANES      (LN),
        .STARVE_LIM (LIM)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
`ifdef SRAMC_ARB_STATS_EN
        .i_stats_clr  (stats_clr),
        .o_conflicts  (conflicts),
        .o_dma_forced (dma_forced),
`endif
        .bus          (bus)
    );

    function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
        return {4{32'hA5A5_0000 | {21'b0, a}}};
    endfunction

    function automatic logic [DW-1:0] rnd();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // SRAM: read data appears the cycle after the access, junk otherwise
    logic [DW-1:0] sram_q;
    always @(posedge clk) begin
        if (bus.o_sram_cen && !bus.o_sram_wen) sram_q <= mem_val(bus.o_sram_adr);
        else sram_q <= rnd();
    end
    assign bus.i_sram_rdata = sram_q;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chb(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Reference: count of core wins over a waiting DMA, and a debt flag
    typedef struct {
        int            due;
        bit            dma;
        logic [DW-1:0] data;
    } rsp_t;

    rsp_t rsp_q[$];
    int   cyc = 0;
    int   streak = 0;
    bit   owed = 0;
    int   core_gnts = 0;
    int   dma_gnts = 0;

    task automatic step(input bit r, input bit cq, input bit cw, input logic [AW-1:0] ca,
                        input logic [DW-1:0] cd, input logic [LN-1:0] cm,
                        input bit dq, input bit dw, input logic [AW-1:0] da,
                        input logic [DW-1:0] dd, input logic [LN-1:0] dm, input bit st);
        bit            eg_c, eg_d, wr, ev_c, ev_d, eb, owed0;
        logic [DW-1:0] em, ed;
        logic [LN-1:0] m;
        @(negedge clk);
        rst = r;
        bus.i_core_req = cq; bus.i_core_wr = cw; bus.i_core_adr = ca;
        bus.i_core_wdata = cd; bus.i_core_wmask = cm;
        bus.i_dma_req = dq; bus.i_dma_wr = dw; bus.i_dma_adr = da;
        bus.i_dma_wdata = dd; bus.i_dma_wmask = dm;
        bus.i_stall = st;
        #1;
        if (r) begin
            rsp_q.delete();
            streak = 0;
            owed = 0;
`ifdef SRAMC_ARB_STATS_EN
            m_conf = 0;
            m_forced = 0;
`endif
        end
        eg_c = 0;
        eg_d = 0;
        if (!st) begin
            if (cq && dq) begin
                eg_d = owed;
                eg_c = !owed;
            end else begin
                eg_c = cq;
                eg_d = dq;
            end
        end
        chb("core_gnt", bus.o_core_gnt, eg_c);
        chb("dma_gnt", bus.o_dma_gnt, eg_d);
        chb("sram_cen", bus.o_sram_cen, eg_c | eg_d);
        if (eg_c | eg_d) begin
            wr = eg_d ? dw : cw;
            m = eg_d ? dm : cm;
            chb("sram_wen", bus.o_sram_wen, wr);
            chk("sram_adr", DW'(bus.o_sram_adr), DW'(eg_d ? da : ca));
            if (wr) begin
                for (int b = 0; b < DW; b++) em[b] = m[b / LW];
                chk("sram_wdata", bus.o_sram_wdata, eg_d ? dd : cd);
                chk("sram_wmask", bus.o_sram_wmask, em);
            end
        end
        ev_c = 0;
        ev_d = 0;
        ed = '0;
        if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
            ev_c = !rsp_q[0].dma;
            ev_d = rsp_q[0].dma;
            ed = rsp_q[0].data;
        end
        chb("core_rvalid", bus.o_core_rvalid, ev_c);
        chb("dma_rvalid", bus.o_dma_rvalid, ev_d);
        if (ev_c | ev_d | r) chk("rdata", bus.o_rdata, ed);
        eb = 0;
        foreach (rsp_q[i]) if (rsp_q[i].due <= cyc + 1) eb = 1;
        chb("busy", bus.o_busy, eb);
        if (rsp_q.size() > 0 && rsp_q[0].due == cyc) void'(rsp_q.pop_front());
        if (eg_c) core_gnts++;
        if (eg_d) dma_gnts++;
        owed0 = owed;
        if (!r && !st) begin
            if (owed) begin
                if (eg_d || !dq) owed = 0;
                streak = 0;
            end else if (eg_c && dq) begin
                streak++;
                if (streak >= LIM) begin
                    streak = 0;
                    owed = 1;
                end
            end else begin
                streak = 0;
            end
        end
        if (!r && ((eg_c && !cw) || (eg_d && !dw)))
            rsp_q.push_back('{cyc + 2, eg_d, mem_val(eg_d ? da : ca)});
`ifdef SRAMC_ARB_STATS_EN
        if (!r && !stats_clr) begin
            if (cq && dq) m_conf++;
            if (eg_d && cq && owed0) m_forced++;
        end
        if (stats_clr) begin
            m_conf = 0;
            m_forced = 0;
        end
`endif
        cyc++;
    endtask

    task automatic go(input bit cq, input bit cw, input logic [AW-1:0] ca,
                      input bit dq, input bit dw, input logic [AW-1:0] da, input bit st);
        step(1'b0, cq, cw, ca, rnd(), LN'($urandom()), dq, dw, da, rnd(), LN'($urandom()), st);
    endtask

    task automatic idle();
        go(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic rst_step();
        step(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    endtask

    int d0, c0;

    initial begin
        bus.i_core_req = 0; bus.i_core_wr = 0; bus.i_core_adr = '0;
        bus.i_core_wdata = '0; bus.i_core_wmask = '0;
        bus.i_dma_req = 0; bus.i_dma_wr = 0; bus.i_dma_adr = '0;
        bus.i_dma_wdata = '0; bus.i_dma_wmask = '0;
        bus.i_stall = 0;

        rst_step();
        rst_step();
        idle();

        go(1'b1, 1'b0, 11'h010, 1'b0, 1'b0, '0, 1'b0);
        idle();
        idle();
        chb("rd10_rvalid", bus.o_core_rvalid, 1'b1);
        chk("rd10_data", bus.o_rdata, {4{32'hA5A5_0010}});
        idle();

        step(1'b0, 1'b1, 1'b1, 11'h020, rnd(), 4'b0101, 1'b0, 1'b0, '0, '0, '0, 1'b0);
        chk("wmask_0101", bus.o_sram_wmask,
            {32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF});
        idle();

        d0 = dma_gnts;
        c0 = core_gnts;
        repeat (27) go(1'b1, 1'b0, AW'($urandom()), 1'b1, 1'b0, AW'($urandom()), 1'b0);
        chk("starve_dma", DW'(dma_gnts - d0), DW'(3));
        chk("starve_core", DW'(core_gnts - c0), DW'(24));

        repeat (4) go(1'b1, 1'b0, AW'($urandom()), 1'b1, 1'b0, AW'($urandom()), 1'b0);
        c0 = core_gnts;
        d0 = dma_gnts;
        repeat (3) go(1'b1, 1'b0, AW'($urandom()), 1'b1, 1'b0, AW'($urandom()), 1'b1);
        chk("stall_nognt", DW'(core_gnts + dma_gnts - c0 - d0), DW'(0));
        repeat (4) go(1'b1, 1'b0, AW'($urandom()), 1'b1, 1'b0, AW'($urandom()), 1'b0);
        chk("stall_resume", DW'(dma_gnts - d0), DW'(0));
        go(1'b1, 1'b0, AW'($urandom()), 1'b1, 1'b0, AW'($urandom()), 1'b0);
        chk("stall_dma_turn", DW'(dma_gnts - d0), DW'(1));
        repeat (3) idle();

        for (int i = 0; i < 10; i++)
            go(i % 2 == 0, 1'b0, AW'(i), i % 2 == 1, 1'b0, AW'(i + 100), 1'b0);
        repeat (3) idle();

        go(1'b1, 1'b0, 11'h055, 1'b0, 1'b0, '0, 1'b0);
        rst_step();
        chb("rst_busy", bus.o_busy, 1'b0);
        repeat (4) idle();

        repeat (400) begin
            go(1'($urandom()), 1'($urandom_range(0, 3) == 0), AW'($urandom()),
               1'($urandom()), 1'($urandom_range(0, 3) == 0), AW'($urandom()),
               $urandom_range(0, 7) == 0);
        end
        repeat (3) idle();

`ifdef SRAMC_ARB_STATS_EN
        chk("conflicts", DW'(conflicts), DW'(m_conf));
        chk("dma_forced", DW'(dma_forced), DW'(m_forced));
        stats_clr = 1'b1;
        idle();
        @(posedge clk);
        #1;
        stats_clr = 1'b0;
        chk("conflicts_clr", DW'(conflicts), DW'(0));
        chk("forced_clr", DW'(dma_forced), DW'(0));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
